// File: rtl/seq_gen_if.sv
// seq_gen request/stream bundle.
// master drives the request, slave returns the serial stream.
interface seq_gen_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic             dout;
  logic             valid;
  logic             first;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  dout, valid, first, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output dout, valid, first, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: MSB-first, repeated with idle gaps.
// All outputs are registered one cycle behind the state.
module seq_gen #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic     clk,
  input  logic     rst,
  seq_gen_if.slave bus
);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE, SHIFT, GAP_ST, FIN
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             skip_q, skip_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_eff;

  assign len_eff = (bus.len > LEN_W'(PAT_W)) ?
                   LEN_W'(PAT_W) : bus.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      skip_q  <= 1'b0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      skip_q  <= skip_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    skip_d  = skip_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d  = bus.pattern;
          rep_d  = bus.reps;
          last_d = IDX_W'(len_eff - LEN_W'(1));
          idx_d  = IDX_W'(len_eff - LEN_W'(1));
          // empty request still pays the one-cycle capture latency
          if (len_eff == '0 || bus.reps == '0) begin
            state_d = FIN;
            skip_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          idx_d = last_q;
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = FIN;
          end else if (GAP > 0) begin
            state_d = GAP_ST;
            gap_d   = GAP_W'(GAP - 1);
          end
        end
      end
      GAP_ST: begin
        if (gap_q == '0) state_d = SHIFT;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      FIN: begin
        if (skip_q) skip_d  = 1'b0;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_q == SHIFT);
    dout_d  = valid_d & pat_q[idx_q];
    first_d = valid_d & (idx_q == last_q);
    busy_d  = (state_q == SHIFT) || (state_q == GAP_ST);
    done_d  = (state_q == FIN) & ~skip_q;
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.first = first_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: one GAP=2 and one GAP=0 instance.
// Expected beats are queued at stimulus time; monitors pop on valid/done.
module tb_seq_gen;
  localparam int PAT_W = 16;
  localparam int LEN_W = 5;
  localparam int CNT_W = 8;

  typedef struct {
    int   cyc;
    logic d;
    logic f;
    logic b;
    logic dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) ifg ();
  seq_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) ifz ();

  seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(2)) u_gap (
    .clk (clk),
    .rst (rst),
    .bus (ifg)
  );

  seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(0)) u_nogap (
    .clk (clk),
    .rst (rst),
    .bus (ifz)
  );

  exp_t qg[$];
  exp_t qz[$];
  int   cnt = 0;
  int   t0 = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic push(input int sel, input int c, input logic d,
                      input logic f, input logic b, input logic dn);
    exp_t e;
    e.cyc = c; e.d = d; e.f = f; e.b = b; e.dn = dn;
    if (sel == 0) qg.push_back(e);
    else          qz.push_back(e);
  endtask

  task automatic model(input int sel, input logic [15:0] pat,
                       input int len, input int reps, input int gap);
    int le;
    int c;
    le = (len > PAT_W) ? PAT_W : len;
    c  = 1;
    if (le == 0 || reps == 0) begin
      push(sel, 2, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    for (int r = 0; r < reps; r++) begin
      for (int i = le - 1; i >= 0; i--) begin
        push(sel, c, pat[i], (i == le - 1), 1'b1, 1'b0);
        c++;
      end
      if (r < reps - 1) c += gap;
    end
    push(sel, c, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input exp_t e, input int rel,
                     input logic d, input logic f, input logic b,
                     input logic dn);
    n_chk++;
    if (rel != e.cyc || d !== e.d || f !== e.f ||
        b !== e.b || dn !== e.dn) begin
      n_fail++;
      $display("FAIL %s beat: got cyc=%0d dout=%b first=%b busy=%b done=%b, expected cyc=%0d dout=%b first=%b busy=%b done=%b",
               nm, rel, d, f, b, dn, e.cyc, e.d, e.f, e.b, e.dn);
    end
  endtask

  task automatic spurious(input string nm, input int rel,
                          input logic v, input logic dn);
    n_chk++;
    n_fail++;
    $display("FAIL %s unexpected beat: got cyc=%0d valid=%b done=%b, expected none",
             nm, rel, v, dn);
  endtask

  task automatic idle_chk(input string nm, input logic d);
    n_chk++;
    if (d !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle dout: got %b, expected 0", nm, d);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifg.valid || ifg.done) begin
        if (qg.size() == 0) spurious("gap2", cnt - t0, ifg.valid, ifg.done);
        else chk("gap2", qg.pop_front(), cnt - t0,
                 ifg.dout, ifg.first, ifg.busy, ifg.done);
      end else begin
        idle_chk("gap2", ifg.dout);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifz.valid || ifz.done) begin
        if (qz.size() == 0) spurious("gap0", cnt - t0, ifz.valid, ifz.done);
        else chk("gap0", qz.pop_front(), cnt - t0,
                 ifz.dout, ifz.first, ifz.busy, ifz.done);
      end else begin
        idle_chk("gap0", ifz.dout);
      end
    end
  end

  task automatic drive(input int sel, input logic s, input logic [15:0] p,
                       input logic [4:0] l, input logic [7:0] r);
    if (sel == 0) begin
      ifg.start = s; ifg.pattern = p; ifg.len = l; ifg.reps = r;
    end else begin
      ifz.start = s; ifz.pattern = p; ifz.len = l; ifz.reps = r;
    end
  endtask

  // returns at the negedge after the capture edge (edge 0)
  task automatic go(input int sel, input logic [15:0] p,
                    input logic [4:0] l, input logic [7:0] r,
                    input bit hold);
    @(negedge clk);
    drive(sel, 1'b1, p, l, r);
    t0 = cnt + 1;
    @(negedge clk);
    if (!hold)
      drive(sel, 1'b0, 16'($urandom), 5'($urandom), 8'($urandom));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (qg.size() == 0 && qz.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (qg.size() != 0 || qz.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d/%0d beats pending, expected 0",
               nm, qg.size(), qz.size());
      qg.delete();
      qz.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    n_chk++;
    if ({ifg.valid, ifg.dout, ifg.first, ifg.busy, ifg.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s gap2 outputs: got v/d/f/b/dn=%b%b%b%b%b, expected 00000",
               nm, ifg.valid, ifg.dout, ifg.first, ifg.busy, ifg.done);
    end
    n_chk++;
    if ({ifz.valid, ifz.dout, ifz.first, ifz.busy, ifz.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s gap0 outputs: got v/d/f/b/dn=%b%b%b%b%b, expected 00000",
               nm, ifz.valid, ifz.dout, ifz.first, ifz.busy, ifz.done);
    end
  endtask

  task automatic push_t1(input int off);
    push(0, off + 1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(0, off + 2, 1'b1, 1'b0, 1'b1, 1'b0);
    push(0, off + 3, 1'b0, 1'b0, 1'b1, 1'b0);
    push(0, off + 4, 1'b1, 1'b0, 1'b1, 1'b0);
    push(0, off + 5, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // 0xD, len 4, once
    push_t1(0);
    go(0, 16'h000D, 5'd4, 8'd1, 1'b0);
    drain("t1");

    // 3'b101 three times with 2-cycle gaps
    for (int r = 0; r < 3; r++) begin
      push(0, 1 + 5 * r, 1'b1, 1'b1, 1'b1, 1'b0);
      push(0, 2 + 5 * r, 1'b0, 1'b0, 1'b1, 1'b0);
      push(0, 3 + 5 * r, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    push(0, 14, 1'b0, 1'b0, 1'b0, 1'b1);
    go(0, 16'h0005, 5'd3, 8'd3, 1'b0);
    drain("t2");

    // start held high: second run accepted at edge 6
    push_t1(0);
    push_t1(6);
    go(0, 16'h000D, 5'd4, 8'd1, 1'b1);
    repeat (6) @(negedge clk);
    drive(0, 1'b0, '0, '0, '0);
    drain("t3_hold");

    push(0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    go(0, 16'hFFFF, 5'd0, 8'd5, 1'b0);
    drain("t4_len0");

    push(0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    go(0, 16'hFFFF, 5'd4, 8'd0, 1'b0);
    drain("t4_reps0");

    model(0, 16'hA5C3, 20, 1, 2);
    go(0, 16'hA5C3, 5'd20, 8'd1, 1'b0);
    drain("t4_len20");

    // abort by reset sampled at edge 4
    push(0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    push(0, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    go(0, 16'h0005, 5'd3, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("t5_abort");
    rst = 1'b0;
    drain("t5_abort");

    push_t1(0);
    go(0, 16'h000D, 5'd4, 8'd1, 1'b0);
    drain("t5_restart");

    // back-to-back repetitions
    push(1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1, 4, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, 6, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    go(1, 16'h0006, 5'd3, 8'd2, 1'b0);
    drain("t6_gap0");

    model(1, 16'h0002, 2, 255, 0);
    go(1, 16'h0002, 5'd2, 8'd255, 1'b0);
    drain("reps_max_gap0");

    model(0, 16'h0001, 1, 255, 2);
    go(0, 16'h0001, 5'd1, 8'd255, 1'b0);
    drain("reps_max_gap2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
